// File: rtl/opcode_fetch.sv
// Instruction fetch/predecode for the 6502 core: owns the PC, reads opcode and
// operand bytes, sizes the instruction, injects interrupts and hands off to decode.
module opcode_fetch #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   output logic       mem_rd,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_data_in,
   input  logic       pc_load,
   input  logic [7:0] pc_load_addr,
   input  logic       nmi,
   input  logic       irq,
   input  logic       irq_mask,
   output logic       int_ack,
   output logic [1:0] int_kind,
   output logic [7:0] instruction,
   output logic [7:0] operand_lo,
   output logic [7:0] operand_hi,
   output logic [1:0] instr_len,
   output logic [7:0] instr_pc,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [2:0] dbg_state
);

   // Handshake: decode takes the instruction on a rising clk edge where
   // instr_valid and instr_ready are both 1; outputs hold while valid and not ready.

   typedef enum logic [2:0] {
      S_REQ  = 3'd0,
      S_OP   = 3'd1,
      S_B1   = 3'd2,
      S_B2   = 3'd3,
      S_HOLD = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] instr_q, instr_d;
   logic [7:0] op_lo_q, op_lo_d;
   logic [7:0] op_hi_q, op_hi_d;
   logic [1:0] len_q, len_d;
   logic [7:0] ipc_q, ipc_d;
   logic [1:0] kind_q, kind_d;
   logic       int_take;
   logic [1:0] op_len;

   function automatic logic [1:0] len_of(input logic [7:0] op);
      logic [3:0] lo_n;
      lo_n = op[3:0];
      if (lo_n == 4'h8 || lo_n == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60)
         len_of = 2'd1;
      else if (lo_n == 4'hC || lo_n == 4'hD || lo_n == 4'hE || op == 8'h20 ||
               (lo_n == 4'h9 && op[4]))
         len_of = 2'd3;
      else
         len_of = 2'd2;
   endfunction

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      op_lo_d  = op_lo_q;
      op_hi_d  = op_hi_q;
      len_d    = len_q;
      ipc_d    = ipc_q;
      kind_d   = kind_q;
      mem_rd   = 1'b0;
      mem_addr = 8'h00;
      int_ack  = 1'b0;
      int_take = nmi | (irq & ~irq_mask);
      op_len   = len_of(mem_data_in);

      if (rst) begin
         state_d = S_REQ;
      end else if (pc_load) begin
         pc_d    = pc_load_addr;
         state_d = S_REQ;
      end else if (rdy) begin
         case (state_q)
            S_REQ: begin
               if (int_take) begin
                  instr_d = 8'h00;
                  op_lo_d = 8'h00;
                  op_hi_d = 8'h00;
                  len_d   = 2'd1;
                  ipc_d   = pc_q;
                  kind_d  = nmi ? 2'b10 : 2'b01;
                  int_ack = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  mem_rd   = 1'b1;
                  mem_addr = pc_q;
                  state_d  = S_OP;
               end
            end
            S_OP: begin
               instr_d = mem_data_in;
               ipc_d   = pc_q;
               len_d   = op_len;
               kind_d  = 2'b00;
               op_lo_d = 8'h00;
               op_hi_d = 8'h00;
               if (op_len != 2'd1) begin
                  mem_rd   = 1'b1;
                  mem_addr = pc_q + 8'd1;
                  state_d  = S_B1;
               end else begin
                  state_d  = S_HOLD;
               end
            end
            S_B1: begin
               op_lo_d = mem_data_in;
               if (len_q == 2'd3) begin
                  mem_rd   = 1'b1;
                  mem_addr = pc_q + 8'd2;
                  state_d  = S_B2;
               end else begin
                  state_d  = S_HOLD;
               end
            end
            S_B2: begin
               op_hi_d = mem_data_in;
               state_d = S_HOLD;
            end
            S_HOLD: begin
               // Injected interrupts leave the PC at the return address.
               if (instr_ready) begin
                  pc_d    = (kind_q == 2'b00) ? (ipc_q + {6'b0, len_q}) : pc_q;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         instr_q <= 8'h00;
         op_lo_q <= 8'h00;
         op_hi_q <= 8'h00;
         len_q   <= 2'd0;
         ipc_q   <= 8'h00;
         kind_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         op_lo_q <= op_lo_d;
         op_hi_q <= op_hi_d;
         len_q   <= len_d;
         ipc_q   <= ipc_d;
         kind_q  <= kind_d;
      end
   end

   assign instruction = instr_q;
   assign operand_lo  = op_lo_q;
   assign operand_hi  = op_hi_q;
   assign instr_len   = len_q;
   assign instr_pc    = ipc_q;
   assign int_kind    = kind_q;
   assign instr_valid = (state_q == S_HOLD);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// Bench for opcode_fetch: program memory model plus a per-instruction reference
// built from the opcode length rules, with directed and randomized scenarios.
module tb_opcode_fetch;

   logic       clk = 1'b0;
   logic       rst, rdy, mem_rd, pc_load, nmi, irq, irq_mask, int_ack;
   logic       instr_valid, instr_ready;
   logic [7:0] mem_addr, mem_data_in, pc_load_addr, instruction, operand_lo, operand_hi, instr_pc;
   logic [1:0] int_kind, instr_len;
   logic [2:0] dbg_state;

   logic [7:0] mem [256];
   logic [7:0] model_pc;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Program memory: data appears the cycle after a read and holds otherwise.
   always @(posedge clk) if (mem_rd) mem_data_in <= mem[mem_addr];

   opcode_fetch #(.RESET_PC(8'h10)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
      .nmi(nmi), .irq(irq), .irq_mask(irq_mask), .int_ack(int_ack), .int_kind(int_kind),
      .instruction(instruction), .operand_lo(operand_lo), .operand_hi(operand_hi),
      .instr_len(instr_len), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .dbg_state(dbg_state)
   );

   function automatic int ref_len(input logic [7:0] op);
      int hi, lo;
      hi = int'(op) / 16;
      lo = int'(op) % 16;
      if (op == 8'h00 || op == 8'h40 || op == 8'h60 || lo == 8 || lo == 10) return 1;
      if (op == 8'h20 || (lo >= 12 && lo <= 14) || (lo == 9 && hi % 2 == 1)) return 3;
      return 2;
   endfunction

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rst = 1; rdy = 1; pc_load = 0; nmi = 0; irq = 0; irq_mask = 0; instr_ready = 0;
         #1;
      end
      vectors++;
      if ({instr_valid, mem_rd, int_ack, int_kind, instruction, operand_lo, operand_hi,
           instr_len, instr_pc} !== 39'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b rd=%b ack=%b kind=%b op=%h lo=%h hi=%h len=%0d pc=%h, want all zero",
                  instr_valid, mem_rd, int_ack, int_kind, instruction, operand_lo, operand_hi, instr_len, instr_pc);
      end
      model_pc = 8'h10;
   endtask

   // Runs one instruction from REQ through handshake; DUT must be at a boundary.
   task automatic fetch_check(input string name, input int stall, input int hold,
                              input bit inj_nmi, input bit inj_irq, input bit mask,
                              input bit redir, input logic [7:0] redir_addr);
      logic [7:0]  op, lo, hi, a;
      logic [1:0]  kind;
      logic [7:0]  exp_reads[$], obs_reads[$];
      logic [31:0] exp_pk, obs_pk;
      logic [35:0] exp_out;
      int len, lat, acks, exp_lat;
      kind = inj_nmi ? 2'b10 : ((inj_irq && !mask) ? 2'b01 : 2'b00);
      op = 8'h00; lo = 8'h00; hi = 8'h00; len = 1;
      if (kind == 2'b00) begin
         op  = mem[model_pc];
         len = ref_len(op);
         for (int i = 0; i < len; i++) begin
            a = model_pc + 8'(i);
            exp_reads.push_back(a);
         end
         if (len > 1) lo = mem[exp_reads[1]];
         if (len > 2) hi = mem[exp_reads[2]];
      end
      exp_out = {op, lo, hi, 2'(len), model_pc, kind};
      exp_lat = (kind != 2'b00) ? 1 : len + 1 + stall;
      lat = -1;
      acks = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         rst = 0; instr_ready = 0; pc_load = 0; irq_mask = mask;
         rdy = !(k >= 1 && k <= stall);
         nmi = (k == 0) && inj_nmi;
         irq = (k == 0) && inj_irq;
         #1;
         if (k == 0) begin
            vectors++;
            if (instr_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL %s valid_at_boundary: got %b want 0", name, instr_valid);
            end
         end
         if (instr_valid === 1'b1) begin
            lat = k;
            break;
         end
         if (mem_rd === 1'b1) obs_reads.push_back(mem_addr);
         if (int_ack === 1'b1) acks++;
      end
      nmi = 0; irq = 0; rdy = 1;
      vectors++;
      if (lat !== exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d cycles want %0d (-1 = timeout)", name, lat, exp_lat);
      end
      if (lat < 0) return;
      exp_pk = 32'(exp_reads.size()) << 24;
      obs_pk = 32'(obs_reads.size()) << 24;
      for (int i = 0; i < 3; i++) begin
         if (i < exp_reads.size()) exp_pk[23-8*i -: 8] = exp_reads[i];
         if (i < obs_reads.size()) obs_pk[23-8*i -: 8] = obs_reads[i];
      end
      vectors++;
      if (obs_pk !== exp_pk) begin
         miscompares++;
         $display("FAIL %s read_addrs: got count/addrs %h want %h", name, obs_pk, exp_pk);
      end
      vectors++;
      if (acks !== ((kind != 2'b00) ? 1 : 0)) begin
         miscompares++;
         $display("FAIL %s int_ack_pulses: got %0d want %0d", name, acks, (kind != 2'b00) ? 1 : 0);
      end
      vectors++;
      if ({instruction, operand_lo, operand_hi, instr_len, instr_pc, int_kind} !== exp_out) begin
         miscompares++;
         $display("FAIL %s outputs: got op=%h lo=%h hi=%h len=%0d pc=%h kind=%b want op=%h lo=%h hi=%h len=%0d pc=%h kind=%b",
                  name, instruction, operand_lo, operand_hi, instr_len, instr_pc, int_kind,
                  op, lo, hi, len, model_pc, kind);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         instr_ready = 0; rdy = 1;
         #1;
         vectors++;
         if ({instr_valid, mem_rd, instruction, operand_lo, operand_hi, instr_len, instr_pc, int_kind}
             !== {1'b1, 1'b0, exp_out}) begin
            miscompares++;
            $display("FAIL %s hold_stable[%0d]: got v=%b rd=%b op=%h lo=%h hi=%h len=%0d pc=%h kind=%b",
                     name, h, instr_valid, mem_rd, instruction, operand_lo, operand_hi, instr_len, instr_pc, int_kind);
         end
      end
      @(negedge clk);
      instr_ready = 1; rdy = 1; pc_load = redir; pc_load_addr = redir_addr;
      #1;
      if (redir) model_pc = redir_addr;
      else if (kind == 2'b00) model_pc = model_pc + 8'(len);
   endtask

   task automatic test_basic();
      mem[8'h10] = 8'hA9; mem[8'h11] = 8'h42; mem[8'h12] = 8'hEA;
      fetch_check("lda_imm", 0, 0, 0, 0, 0, 0, 8'h00);
      fetch_check("nop_at_12", 0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_hold_stable();
      mem[model_pc] = 8'h8D; mem[model_pc + 8'd1] = 8'h00; mem[model_pc + 8'd2] = 8'h02;
      fetch_check("hold_5", 0, 5, 0, 0, 0, 1, 8'hFE);
   endtask

   task automatic test_wrap();
      mem[8'hFE] = 8'h4C; mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12; mem[8'h01] = 8'h60;
      fetch_check("jmp_wrap", 0, 0, 0, 0, 0, 0, 8'h00);
      fetch_check("rts_at_01", 0, 1, 0, 0, 0, 1, 8'h20);
   endtask

   task automatic test_interrupts();
      mem[8'h20] = 8'h20; mem[8'h21] = 8'hCD; mem[8'h22] = 8'hAB;
      fetch_check("irq_inject", 0, 1, 0, 1, 0, 0, 8'h00);
      fetch_check("nmi_over_irq", 0, 0, 1, 1, 0, 0, 8'h00);
      fetch_check("irq_masked", 0, 0, 0, 1, 1, 0, 8'h00);
   endtask

   task automatic test_pc_load_b1();
      mem[model_pc] = 8'hAD; mem[model_pc + 8'd1] = 8'h77; mem[model_pc + 8'd2] = 8'h66;
      mem[8'h80] = 8'hA2; mem[8'h81] = 8'h55;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         instr_ready = 0; rdy = 1; pc_load = (k == 2); pc_load_addr = 8'h80;
         #1;
         vectors++;
         if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pc_load_b1 valid[%0d]: got %b want 0", k, instr_valid);
         end
      end
      model_pc = 8'h80;
      fetch_check("after_redirect", 0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_rdy_stall();
      mem[model_pc] = 8'hA9; mem[model_pc + 8'd1] = 8'h33;
      fetch_check("rdy_stall_3", 3, 1, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_lengths();
      logic [7:0] ops [8];
      ops = '{8'h00, 8'h40, 8'h0A, 8'h99, 8'h89, 8'h6C, 8'hB1, 8'h19};
      for (int i = 0; i < 8; i++) begin
         mem[model_pc] = ops[i];
         mem[model_pc + 8'd1] = 8'($urandom);
         mem[model_pc + 8'd2] = 8'($urandom);
         fetch_check($sformatf("len_op_%h", ops[i]), 0, 0, 0, 0, 0, 0, 8'h00);
      end
   endtask

   task automatic test_reset_mid_fetch();
      mem[model_pc] = 8'h6D;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rst = 0; instr_ready = 0; rdy = 1; pc_load = 0;
         #1;
      end
      test_reset();
      mem[8'h10] = 8'hA9; mem[8'h11] = 8'h42;
      fetch_check("after_mid_reset", 0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_random();
      bit inj_n, inj_i, msk, rd;
      for (int n = 0; n < 60; n++) begin
         mem[model_pc]        = 8'($urandom);
         mem[model_pc + 8'd1] = 8'($urandom);
         mem[model_pc + 8'd2] = 8'($urandom);
         inj_n = ($urandom_range(0, 9) == 0);
         inj_i = ($urandom_range(0, 5) == 0);
         msk   = $urandom_range(0, 1) == 1;
         rd    = ($urandom_range(0, 3) == 0);
         fetch_check($sformatf("rand_%0d", n), (inj_n || inj_i) ? 0 : $urandom_range(0, 2),
                     $urandom_range(0, 3), inj_n, inj_i, msk, rd, 8'($urandom));
      end
   endtask

   initial begin
      rst = 1; rdy = 1; pc_load = 0; pc_load_addr = 8'h00; nmi = 0; irq = 0;
      irq_mask = 0; instr_ready = 0; mem_data_in = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'hEA;
      test_reset();
      test_basic();
      test_hold_stable();
      test_wrap();
      test_interrupts();
      test_pc_load_b1();
      test_rdy_stall();
      test_lengths();
      test_reset_mid_fetch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
